// File: rtl/pc_fetch.sv
// Program-counter stage with run / single-step / halt control and a saturating
// executed-instruction counter. Define PC_FETCH_STEP_EN to build single-step support.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         NextPC,
    input  logic                halt,
    input  logic                go,
    input  logic                step_mode,
    output logic [31:0]         PC,
    output logic                exec,
    output logic                halted,
    output logic [CNT_BITS-1:0] total,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic                go_q;
    logic                go_rise;
    logic [CNT_BITS-1:0] total_q, total_d;
    logic                step_en;

`ifdef PC_FETCH_STEP_EN
    assign step_en = step_mode;
`else
    assign step_en = 1'b0;
    logic unused_step;
    assign unused_step = step_mode;
`endif

    logic unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, NextPC[1:0]};

    // go is a level; only a 0->1 transition requests an action.
    assign go_rise = go & ~go_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            go_q    <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            go_q    <= go;
            total_q <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALTED;
                end else if (step_en) begin
                    state_d = S_WAIT;
                end
            end
`ifdef PC_FETCH_STEP_EN
            S_WAIT: begin
                if (go_rise) begin
                    state_d = S_RUN;
                end
            end
`endif
            S_HALTED: begin
                if (go_rise) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Resuming from halt skips the syscall that stopped the machine.
    always_comb begin
        pc_d = pc_q;
        if (state_q == S_RUN && !halt) begin
            pc_d = {NextPC[31:2], 2'b00};
        end else if (state_q == S_HALTED && go_rise) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        total_d = total_q;
        if (state_q == S_RUN && total_q != {CNT_BITS{1'b1}}) begin
            total_d = total_q + CNT_BITS'(1);
        end
    end

    always_comb begin
        PC          = pc_q;
        exec        = (state_q == S_RUN);
        halted      = (state_q == S_HALTED);
        total       = total_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios plus random stimulus against a
// behavioural model. Works with or without PC_FETCH_STEP_EN defined.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        halt;
    logic        go;
    logic        step_mode;
    logic [31:0] pc;
    logic        exec;
    logic        halted;
    logic [15:0] total;
    logic [1:0]  dbg_state;
    logic [31:0] pc_s;
    logic        exec_s;
    logic        halted_s;
    logic [3:0]  total_s;
    logic [1:0]  dbg_state_s;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the machine is either running, paused for a step, or halted.
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_paused;
    int          m_total;
    int          m_total_s;
    logic        m_prev_go;

    pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .NextPC(next_pc), .halt(halt), .go(go),
        .step_mode(step_mode), .PC(pc), .exec(exec), .halted(halted),
        .total(total), .dbg_state_o(dbg_state)
    );

    pc_fetch #(.RESET_PC(32'h0000_0000), .CNT_BITS(4)) dut_small (
        .clk(clk), .rst(rst), .NextPC(next_pc), .halt(halt), .go(go),
        .step_mode(step_mode), .PC(pc_s), .exec(exec_s), .halted(halted_s),
        .total(total_s), .dbg_state_o(dbg_state_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step();
        bit step_on;
        bit rise;
`ifdef PC_FETCH_STEP_EN
        step_on = step_mode;
`else
        step_on = 1'b0;
`endif
        rise = go && !m_prev_go;
        if (rst) begin
            m_pc = 32'h0; m_halted = 0; m_paused = 0;
            m_total = 0; m_total_s = 0; m_prev_go = 0;
        end else begin
            if (!m_halted && !m_paused) begin
                if (m_total < 65535) m_total = m_total + 1;
                if (m_total_s < 15) m_total_s = m_total_s + 1;
                if (halt) m_halted = 1;
                else begin
                    m_pc = next_pc & 32'hFFFF_FFFC;
                    if (step_on) m_paused = 1;
                end
            end else if (m_halted) begin
                if (rise) begin
                    m_pc = m_pc + 32'd4;
                    m_halted = 0;
                end
            end else if (rise) begin
                m_paused = 0;
            end
            m_prev_go = go;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; halt = 0; go = 0; step_mode = 0; next_pc = 32'h0;
        tick();
        tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b exp 0", halted); end
        n_vec++; if (total !== 16'd0) begin n_err++; $display("FAIL reset_total got %0d exp 0", total); end
        rst = 0;
        n_vec++; if (exec !== 1'b1) begin n_err++; $display("FAIL reset_exec got %b exp 1", exec); end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 5; i++) begin
            next_pc = m_pc + 32'd4;
            tick();
            n_vec++;
            if (pc !== 32'(i * 4)) begin n_err++; $display("FAIL free_run_pc got %h exp %h", pc, 32'(i * 4)); end
        end
        n_vec++; if (total !== 16'd5) begin n_err++; $display("FAIL free_run_total got %0d exp 5", total); end
        n_vec++; if (total_s !== 4'd5) begin n_err++; $display("FAIL free_run_total_small got %0d exp 5", total_s); end
    endtask

    task automatic test_jump();
        next_pc = 32'h0000_3007;
        tick();
        n_vec++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL jump_misaligned got %h exp %h", pc, 32'h0000_3004); end
    endtask

    task automatic test_halt_resume();
        int t0;
        next_pc = 32'h40;
        tick();
        t0 = m_total;
        halt = 1;
        tick();
        n_vec++; if (halted !== 1'b1 || pc !== 32'h40 || exec !== 1'b0) begin
            n_err++; $display("FAIL halt_enter got halted=%b pc=%h exec=%b exp 1 00000040 0", halted, pc, exec); end
        n_vec++; if (total !== 16'(t0 + 1)) begin n_err++; $display("FAIL halt_total got %0d exp %0d", total, t0 + 1); end
        for (int i = 0; i < 10; i++) begin
            halt = 1'($urandom_range(0, 1));
            next_pc = $urandom;
            tick();
            n_vec++;
            if (pc !== 32'h40 || halted !== 1'b1 || exec !== 1'b0 || total !== 16'(t0 + 1)) begin
                n_err++; $display("FAIL halt_hold got pc=%h halted=%b exec=%b total=%0d exp 00000040 1 0 %0d",
                                  pc, halted, exec, total, t0 + 1);
            end
        end
        halt = 0; go = 1;
        tick();
        n_vec++; if (pc !== 32'h44 || halted !== 1'b0 || exec !== 1'b1) begin
            n_err++; $display("FAIL resume got pc=%h halted=%b exec=%b exp 00000044 0 1", pc, halted, exec); end
        for (int i = 0; i < 2; i++) begin
            next_pc = 32'h44;
            tick();
            n_vec++; if (pc !== 32'h44 || halted !== 1'b0) begin
                n_err++; $display("FAIL resume_once got pc=%h halted=%b exp 00000044 0", pc, halted); end
        end
        go = 0;
    endtask

    task automatic test_halt_go_same();
        next_pc = 32'h80;
        tick();
        halt = 1; go = 1;
        tick();
        n_vec++; if (halted !== 1'b1 || pc !== 32'h80) begin
            n_err++; $display("FAIL halt_prio got halted=%b pc=%h exp 1 00000080", halted, pc); end
        halt = 0;
        tick();
        n_vec++; if (halted !== 1'b1 || pc !== 32'h80) begin
            n_err++; $display("FAIL held_go got halted=%b pc=%h exp 1 00000080", halted, pc); end
        go = 0;
        tick();
        go = 1;
        tick();
        n_vec++; if (halted !== 1'b0 || pc !== 32'h84) begin
            n_err++; $display("FAIL halt_prio_resume got halted=%b pc=%h exp 0 00000084", halted, pc); end
        go = 0;
    endtask

    task automatic test_wrap();
        next_pc = 32'hFFFF_FFFC;
        tick();
        halt = 1;
        tick();
        halt = 0; go = 1;
        tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL pc_wrap got %h exp 00000000", pc); end
        go = 0;
    endtask

    task automatic test_step();
        logic [31:0] pc0;
        int          t0;
        int          exec_cnt;
        step_mode = 1;
        next_pc = m_pc + 32'd4;
        tick();
        pc0 = m_pc;
        t0 = m_total;
        exec_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 4; j++) begin
                go = (j == 0);
                next_pc = m_pc + 32'd4;
                tick();
                if (exec === 1'b1) exec_cnt++;
            end
        end
        go = 0;
`ifdef PC_FETCH_STEP_EN
        n_vec++; if (exec_cnt != 3) begin n_err++; $display("FAIL step_exec_cycles got %0d exp 3", exec_cnt); end
        n_vec++; if (pc !== pc0 + 32'd12) begin n_err++; $display("FAIL step_pc got %h exp %h", pc, pc0 + 32'd12); end
        n_vec++; if (total !== 16'(t0 + 3)) begin n_err++; $display("FAIL step_total got %0d exp %0d", total, t0 + 3); end
        step_mode = 0;
        tick();
        n_vec++; if (exec !== 1'b0) begin n_err++; $display("FAIL step_clear_waits got exec=%b exp 0", exec); end
        go = 1;
        tick();
        n_vec++; if (exec !== 1'b1) begin n_err++; $display("FAIL step_leave got exec=%b exp 1", exec); end
        go = 0;
`else
        n_vec++; if (exec_cnt != 12) begin n_err++; $display("FAIL nostep_exec_cycles got %0d exp 12", exec_cnt); end
        n_vec++; if (pc !== pc0 + 32'd48) begin n_err++; $display("FAIL nostep_pc got %h exp %h", pc, pc0 + 32'd48); end
        n_vec++; if (total !== 16'(t0 + 12)) begin n_err++; $display("FAIL nostep_total got %0d exp %0d", total, t0 + 12); end
        step_mode = 0;
`endif
    endtask

    task automatic test_saturation();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            next_pc = m_pc + 32'd4;
            tick();
        end
        n_vec++; if (total_s !== 4'd15) begin n_err++; $display("FAIL sat_small got %0d exp 15", total_s); end
        n_vec++; if (total !== 16'd20) begin n_err++; $display("FAIL sat_wide got %0d exp 20", total); end
        halt = 1;
        tick();
        n_vec++; if (halted_s !== 1'b1) begin n_err++; $display("FAIL sat_halt got %b exp 1", halted_s); end
        rst = 1; go = 1;
        tick();
        n_vec++; if (pc !== 32'h0 || halted !== 1'b0 || total !== 16'd0 || total_s !== 4'd0) begin
            n_err++; $display("FAIL reset_in_halt got pc=%h halted=%b total=%0d small=%0d exp 00000000 0 0 0",
                              pc, halted, total, total_s); end
        rst = 0; go = 0; halt = 0;
    endtask

    task automatic test_random();
        logic exp_exec;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            halt      = ($urandom_range(0, 7) == 0);
            go        = ($urandom_range(0, 3) == 0) ? ~go : go;
            step_mode = ($urandom_range(0, 15) == 0) ? ~step_mode : step_mode;
            next_pc   = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            tick();
            exp_exec = !m_halted && !m_paused;
            n_vec++;
            if (pc !== m_pc || exec !== exp_exec || halted !== m_halted ||
                total !== 16'(m_total) || total_s !== 4'(m_total_s)) begin
                n_err++;
                $display("FAIL random_cycle%0d got pc=%h exec=%b halted=%b total=%0d small=%0d exp %h %b %b %0d %0d",
                         i, pc, exec, halted, total, total_s, m_pc, exp_exec, m_halted, m_total, m_total_s);
            end
        end
        rst = 0; halt = 0; go = 0; step_mode = 0;
    endtask

    initial begin
        m_pc = 0; m_halted = 0; m_paused = 0; m_total = 0; m_total_s = 0; m_prev_go = 0;
        rst = 1; halt = 0; go = 0; step_mode = 0; next_pc = 0;
        #1;
        test_reset();
        test_free_run();
        test_jump();
        test_halt_resume();
        test_halt_go_same();
        test_wrap();
        test_step();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
